// File: rtl/axis_mc_pkg.sv
// Shared register map and status/control bit positions for the multi-channel AXI-stream CPU bridge.
// Register offsets are byte offsets within the 256-byte decode window.
package axis_mc_pkg;

  localparam logic [3:0] REG_DATA     = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h4;
  localparam logic [3:0] REG_CTRL     = 4'h8;
  localparam logic [7:0] OFF_IRQ_PEND = 8'h40;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_STALL     = 2;
  localparam int ST_UNDERFLOW = 3;
  localparam int ST_COUNT_LSB = 16;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  typedef struct packed {
    logic stall;
    logic underflow;
  } sticky_t;

  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input sticky_t st, input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[ST_EMPTY]              = empty;
    w[ST_FULL]               = full;
    w[ST_STALL]              = st.stall;
    w[ST_UNDERFLOW]          = st.underflow;
    w[ST_COUNT_LSB +: 8]     = count;
    return w;
  endfunction

endpackage

// File: rtl/axis_mc_fifo.sv
// Synchronous FIFO with combinational head; push/pop take effect at the clock edge.
// Push is ignored when full and pop when empty; flush clears pointers and count, overriding both.
module axis_mc_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr] <= din;
  end

endmodule

// File: rtl/axis_mc_if.sv
// CPU-mapped bridge draining CHANNELS AXI-stream slaves into per-channel FIFOs; read data registered 1 cycle.
// tready drops while a channel FIFO is full; interrupt logic only when AXIS_MC_IRQ_EN is defined.
module axis_mc_if
  import axis_mc_pkg::*;
#(
  parameter int          CHANNELS = 2,
  parameter int          DATA_W   = 8,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] BASE     = 32'he4000000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [31:0]                  addr_i,
  input  logic [31:0]                  data_i,
  input  logic                         data_w_i,
  output logic [31:0]                  data_o,
  output logic                         data_access_o,
  output logic                         irq_o,
  input  logic [CHANNELS-1:0]          s_axis_tvalid_i,
  output logic [CHANNELS-1:0]          s_axis_tready_o,
  input  logic [CHANNELS*DATA_W-1:0]   s_axis_tdata_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]                 off;
  logic                       hit;
  logic                       rd;
  logic                       wr;
  logic                       rd_dly;
  logic [31:0]                prev_addr;
  logic                       held;
  logic                       first_rd;
  logic [31:0]                rdata;
  logic [CHANNELS-1:0]        full;
  logic [CHANNELS-1:0]        empty;
  logic [CHANNELS-1:0]        irq_en;
  logic [CHANNELS-1:0]        pend;
  sticky_t [CHANNELS-1:0]     sticky_v;
  logic [CHANNELS*DATA_W-1:0] head_flat;
  logic [CHANNELS*CW-1:0]     cnt_flat;
  logic                       unused_bits;

  assign off           = addr_i[7:0];
  assign hit           = (addr_i[31:8] == BASE[31:8]);
  assign data_access_o = hit;
  assign rd            = hit && !data_w_i;
  assign wr            = hit && data_w_i;
  // A read held on the same address across cycles is one access: only its first cycle pops.
  assign held          = rd_dly && (prev_addr == addr_i);
  assign first_rd      = rd && !held;
  assign pend          = ~empty & irq_en;
  assign unused_bits   = ^data_i;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic           sel;
    logic           pop;
    logic           push;
    logic           flush;
    logic           st_wr;
    logic           ctrl_wr;
    logic           en;
    logic [CW-1:0]  cnt;
    sticky_t        sticky;

    assign sel     = hit && (off[7:4] == 4'(c));
    assign pop     = first_rd && sel && (off[3:0] == REG_DATA);
    assign st_wr   = wr && sel && (off[3:0] == REG_STATUS);
    assign ctrl_wr = wr && sel && (off[3:0] == REG_CTRL);
    assign flush   = ctrl_wr && data_i[CTRL_FLUSH];
    assign s_axis_tready_o[c] = !full[c] && !rst_i;
    assign push    = s_axis_tvalid_i[c] && s_axis_tready_o[c];

    axis_mc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (s_axis_tdata_i[c*DATA_W +: DATA_W]),
      .dout  (head_flat[c*DATA_W +: DATA_W]),
      .full  (full[c]),
      .empty (empty[c]),
      .count (cnt)
    );

    assign cnt_flat[c*CW +: CW] = cnt;
    assign sticky_v[c]          = sticky;
    assign irq_en[c]            = en;

    // A live stall/underflow condition wins over a same-cycle clear.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sticky <= '0;
      end else begin
        if (st_wr)                         sticky           <= '0;
        if (s_axis_tvalid_i[c] && full[c]) sticky.stall     <= 1'b1;
        if (pop && empty[c])               sticky.underflow <= 1'b1;
      end
    end

`ifdef AXIS_MC_IRQ_EN
    always_ff @(posedge clk_i) begin
      if (rst_i)        en <= 1'b0;
      else if (ctrl_wr) en <= data_i[CTRL_IRQ_EN];
    end
`else
    assign en = 1'b0;
`endif
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (off[7:4] == 4'(c)) begin
        case (off[3:0])
          REG_DATA:   if (!empty[c]) rdata = 32'(head_flat[c*DATA_W +: DATA_W]);
          REG_STATUS: rdata = status_word(empty[c], full[c], sticky_v[c],
                                          8'(cnt_flat[c*CW +: CW]));
          REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en[c];
          default:    ;
        endcase
      end
    end
    if (off == OFF_IRQ_PEND) rdata = 32'(pend);
  end

  // Repeated cycles of a held DATA read keep the value popped on the first cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o    <= '0;
      rd_dly    <= 1'b0;
      prev_addr <= '0;
    end else begin
      rd_dly    <= rd;
      prev_addr <= addr_i;
      if (rd && !(held && off[3:0] == REG_DATA)) data_o <= rdata;
    end
  end

`ifdef AXIS_MC_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= |pend;
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_axis_mc_if.sv
// Directed bench for axis_mc_if at default parameters (2 channels, 8-bit data, depth 8).
module tb_axis_mc_if;

  localparam logic [31:0] B = 32'he4000000;

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_PUSH} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic        we;
  logic [31:0] data_o;
  logic        acc;
  logic        irq;
  logic [1:0]  tvalid;
  logic [1:0]  tready;
  logic [15:0] tdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  axis_mc_if #(
    .CHANNELS (2),
    .DATA_W   (8),
    .DEPTH    (8),
    .BASE     (32'he4000000)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .addr_i          (addr),
    .data_i          (wdat),
    .data_w_i        (we),
    .data_o          (data_o),
    .data_access_o   (acc),
    .irq_o           (irq),
    .s_axis_tvalid_i (tvalid),
    .s_axis_tready_o (tready),
    .s_axis_tdata_i  (tdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
    else passed++;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 1'b0;
    @(posedge clk); #1;
    d = data_o;
    addr = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdat = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; wdat = 32'h0; addr = 32'h0;
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    tvalid[ch] = 1'b1;
    tdata[ch*8 +: 8] = d;
    @(posedge clk); #1;
    tvalid[ch] = 1'b0;
  endtask

  initial begin
    vec_t        vt [NV];
    logic [31:0] r;
    logic        rdy;
    int          idx;

    vt[0]  = '{OP_RD,   B + 32'h04, 32'h0,  32'h00000001};
    vt[1]  = '{OP_RD,   B + 32'h14, 32'h0,  32'h00000001};
    vt[2]  = '{OP_RD,   B + 32'h08, 32'h0,  32'h00000000};
    vt[3]  = '{OP_RD,   B + 32'h40, 32'h0,  32'h00000000};
    vt[4]  = '{OP_RD,   B + 32'h0C, 32'h0,  32'h00000000};
    vt[5]  = '{OP_RD,   B + 32'h34, 32'h0,  32'h00000000};
    vt[6]  = '{OP_PUSH, 32'd0,      32'h5A, 32'h0};
    vt[7]  = '{OP_RD,   B + 32'h04, 32'h0,  32'h00010000};
    vt[8]  = '{OP_RD,   B + 32'h00, 32'h0,  32'h0000005A};
    vt[9]  = '{OP_RD,   B + 32'h04, 32'h0,  32'h00000001};
    vt[10] = '{OP_PUSH, 32'd1,      32'h11, 32'h0};
    vt[11] = '{OP_PUSH, 32'd1,      32'h22, 32'h0};
    vt[12] = '{OP_RD,   B + 32'h14, 32'h0,  32'h00020000};
    vt[13] = '{OP_RD,   B + 32'h10, 32'h0,  32'h00000011};
    vt[14] = '{OP_RD,   B + 32'h10, 32'h0,  32'h00000022};
    vt[15] = '{OP_RD,   B + 32'h10, 32'h0,  32'h00000000};
    vt[16] = '{OP_RD,   B + 32'h14, 32'h0,  32'h00000009};
    vt[17] = '{OP_WR,   B + 32'h14, 32'h0,  32'h0};
    vt[18] = '{OP_RD,   B + 32'h14, 32'h0,  32'h00000001};
    vt[19] = '{OP_WR,   B + 32'h00, 32'hFF, 32'h0};
    vt[20] = '{OP_RD,   B + 32'h04, 32'h0,  32'h00000001};

    rst = 1'b1; addr = 32'h0; wdat = 32'h0; we = 1'b0; tvalid = 2'b00; tdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 32'(tready), 32'h0);
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    #1;
    chk("tready_after_rst", 32'(tready), 32'h3);

    addr = B + 32'h04; #1;
    chk("decode_hit", 32'(acc), 32'h1);
    addr = B + 32'h104; #1;
    chk("decode_miss", 32'(acc), 32'h0);
    addr = 32'h0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      case (vt[i].op)
        OP_RD: begin
          rd(vt[i].a, r);
          chk($sformatf("vec%0d", i), r, vt[i].exp);
        end
        OP_WR:   wr(vt[i].a, vt[i].d);
        default: push(int'(vt[i].a), vt[i].d[7:0]);
      endcase
    end

    // Hold tvalid on ch1 with bytes 1..9 until backpressure appears.
    idx = 0;
    tvalid[1] = 1'b1;
    tdata[15:8] = 8'(idx + 1);
    for (int cyc = 0; cyc < 20 && !(idx == 8 && !tready[1]); cyc++) begin
      rdy = tready[1];
      @(posedge clk); #1;
      if (rdy) begin
        idx++;
        tdata[15:8] = 8'(idx + 1);
      end
    end
    chk("fill_accepted", 32'(idx), 32'd8);
    chk("fill_tready", 32'(tready[1]), 32'h0);
    @(posedge clk); #1;
    rd(B + 32'h14, r);
    chk("full_status", r, 32'h00080006);

    addr = B + 32'h10; we = 1'b0;
    @(posedge clk); #1;
    chk("pop_first", data_o, 32'h00000001);
    chk("tready_reopen", 32'(tready[1]), 32'h1);
    addr = 32'h0;
    @(posedge clk); #1;
    chk("ninth_accepted", 32'(tready[1]), 32'h0);
    tvalid[1] = 1'b0;

    // DATA address held for three cycles pops once.
    addr = B + 32'h10;
    @(posedge clk); #1;
    chk("held_data", data_o, 32'h00000002);
    @(posedge clk);
    @(posedge clk); #1;
    addr = 32'h0;
    @(posedge clk); #1;
    rd(B + 32'h14, r);
    chk("held_status", r, 32'h00070004);

    for (int k = 3; k <= 9; k++) begin
      rd(B + 32'h10, r);
      chk($sformatf("drain%0d", k), r, 32'(k));
    end
    rd(B + 32'h14, r);
    chk("drained_status", r, 32'h00000005);
    wr(B + 32'h14, 32'hFFFFFFFF);
    rd(B + 32'h14, r);
    chk("stall_cleared", r, 32'h00000001);

    // Flush in the same cycle as a push.
    push(0, 8'h33);
    push(0, 8'h44);
    rd(B + 32'h04, r);
    chk("pre_flush", r, 32'h00020000);
    tvalid[0] = 1'b1; tdata[7:0] = 8'h55;
    addr = B + 32'h08; wdat = 32'h2; we = 1'b1;
    @(posedge clk); #1;
    tvalid[0] = 1'b0; we = 1'b0; wdat = 32'h0; addr = 32'h0;
    rd(B + 32'h04, r);
    chk("flush_status", r, 32'h00000001);
    rd(B + 32'h08, r);
    chk("flush_selfclear", r, 32'h00000000);

`ifdef AXIS_MC_IRQ_EN
    wr(B + 32'h08, 32'h1);
    rd(B + 32'h08, r);
    chk("ctrl_irq_en", r, 32'h1);
    chk("irq_idle", 32'(irq), 32'h0);
    push(0, 8'h77);
    @(posedge clk); #1;
    chk("irq_set", 32'(irq), 32'h1);
    rd(B + 32'h40, r);
    chk("irq_pend", r, 32'h1);
    rd(B + 32'h00, r);
    chk("irq_pop", r, 32'h77);
    chk("irq_clear", 32'(irq), 32'h0);
`else
    wr(B + 32'h08, 32'h1);
    rd(B + 32'h08, r);
    chk("ctrl_irq_en", r, 32'h0);
    push(0, 8'h77);
    @(posedge clk); #1;
    chk("irq_tied", 32'(irq), 32'h0);
    rd(B + 32'h40, r);
    chk("irq_pend", r, 32'h0);
    rd(B + 32'h00, r);
    chk("irq_pop", r, 32'h77);
`endif

    // Reset arriving during a read and a push commits neither.
    push(0, 8'hAB);
    addr = B; we = 1'b0; tvalid[0] = 1'b1; tdata[7:0] = 8'hCD; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_tready", 32'(tready), 32'h0);
    rst = 1'b0; tvalid[0] = 1'b0; addr = 32'h0;
    chk("rst_mid_data_o", data_o, 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    rd(B + 32'h04, r);
    chk("rst_mid_status", r, 32'h00000001);
    rd(B + 32'h08, r);
    chk("rst_mid_ctrl", r, 32'h00000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
